img_load_ctrl: RTL and testbench
================================

# img_load_ctrl

Sequencer for the 28x28 input-image BRAM (`bram_ip`) of the NN datapath. It issues the per-frame rescale pulse and loads 28 rows of 28 pixels through the row-parallel load port, one handshaked row at a time, while advancing the row base address. It then streams all 784 pixels out in address order to the first NN layer, with a valid signal aligned to BRAM read latency.

## Interface
- ROWS, 28, rows per frame
- COLS, 28, pixels per row; row base step
- ADDR_W, 11, BRAM address width
- BASE_ADDR, 0, BRAM address of pixel 0
- RD_LAT, 1, BRAM read latency in cycles (1..4)
- TIMEOUT, 255, max cycles in LOAD waiting for load_done
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame (ignored unless IDLE, LOADED or ERR)
- row_valid  in  1  upstream row (DPL_0..27) present and stable
- row_ack  out  1  one-cycle pulse: current row written, upstream may change row
- load_en  out  1  to bram_ip load_en
- rescale  out  1  to bram_ip rescale
- bram_addr  out  ADDR_W  to bram_ip ADDR_IP
- load_done  in  1  from bram_ip
- rd_start  in  1  pulse; begins readout (honoured only in LOADED)
- pix_valid  out  1  D_OUT holds pixel pix_idx this cycle
- pix_idx  out  10  pixel index 0..ROWS*COLS-1 matching D_OUT
- pix_last  out  1  with pix_valid on pixel ROWS*COLS-1
- frame_loaded  out  1  level; all rows written, awaiting rd_start
- frame_done  out  1  one-cycle pulse after last pixel delivered
- busy  out  1  high in any state except IDLE, LOADED, ERR
- err  out  1  sticky load timeout flag

## Operation
- States: IDLE, RESCALE, WAIT_ROW, LOAD, GAP, LOADED, STREAM, DRAIN, ERR.
- IDLE/LOADED/ERR + start -> RESCALE; clears row_cnt, rd_cnt, err; row_base=BASE_ADDR.
- RESCALE: rescale=1 for exactly one cycle -> WAIT_ROW.
- WAIT_ROW: row_valid=1 -> LOAD; else hold.
- LOAD: load_en=1, bram_addr=row_base. load_done=1 -> GAP. Wait counter > TIMEOUT -> ERR.
- GAP: load_en=0, row_ack=1 (single cycle), row_cnt+1, row_base+COLS. If new row_cnt==ROWS -> LOADED else WAIT_ROW. The gap cycle guarantees load_en drops between rows so bram_ip restarts its internal column counter.
- LOADED: frame_loaded=1. rd_start -> STREAM.
- STREAM: bram_addr=BASE_ADDR+rd_cnt, rd_cnt increments every cycle. At rd_cnt==ROWS*COLS-1 -> DRAIN.
- DRAIN: RD_LAT cycles, then -> IDLE with frame_done=1 for one cycle.
- pix_valid/pix_idx/pix_last: STREAM-issue flag, rd_cnt and last flag delayed by an RD_LAT-deep shift register. There is no backpressure; the consumer must accept one pixel per cycle.
- ERR: err=1, load_en=0. Stays in ERR until start or rst.
- Address arithmetic is ADDR_W-bit unsigned with no saturation. BASE_ADDR+ROWS*COLS-1 must fit in ADDR_W; this is a parameter constraint checked at elaboration.
- bram_addr=BASE_ADDR in every state other than LOAD and STREAM.

## Timing
- Reset: all outputs 0, except bram_addr=BASE_ADDR. State IDLE, counters 0, err cleared. rst mid-frame aborts at the next edge; load_en drops in that cycle.
- start at edge n -> rescale high during cycle n+1. The earliest load_en is cycle n+3 if row_valid is already high.
- Per row: 1 WAIT_ROW cycle (min) + load cycles until load_done + 1 GAP cycle.
- rd_start at edge m -> first address in cycle m+1. First pix_valid in cycle m+1+RD_LAT. The pixel stream is 784 consecutive cycles; frame_done follows one cycle after pix_last.
- start during busy: ignored. rd_start outside LOADED: ignored. start in LOADED discards the loaded frame and reloads.
- row_valid dropping during LOAD: ignored; upstream must keep the row stable until row_ack.
- load_done in the same cycle as timeout expiry: load_done wins.

## Test plan
- Reset: hold rst 3 cycles mid-LOAD -> next cycle load_en=0, busy=0, bram_addr=0, err=0.
- Full frame: DPL row r = r*28+1..r*28+28, row_valid always high, start pulse -> exactly 1 rescale pulse, 28 row_ack pulses, bram_addr bases 0,28,...,756, then frame_loaded=1.
- Readout, RD_LAT=1: rd_start -> 784 consecutive pix_valid with D_OUT==pix_idx+1; pix_last only at idx 783; frame_done exactly 1 cycle later.
- Row stall: deassert row_valid 5 cycles before row 3 -> controller holds WAIT_ROW, load_en=0, bram_addr unchanged, no missed or duplicated row.
- Timeout: model bram_ip never asserts load_done, TIMEOUT=15 -> ERR after 16 LOAD cycles, err=1 and load_en=0; start clears err and reloads.
- Ignored commands: rd_start while busy and start during STREAM -> no state change, pixel sequence unbroken; BASE_ADDR=10 run writes bases 10..766.

Source files
------------

// File: rtl/img_load_ctrl_if.sv
// Handshake and bus bundle between the image-load sequencer and its
// surroundings: upstream row source, input-image BRAM and first NN layer.
interface img_load_ctrl_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic              row_valid;
  logic              row_ack;
  logic              load_en;
  logic              rescale;
  logic [ADDR_W-1:0] bram_addr;
  logic              load_done;
  logic              rd_start;
  logic              pix_valid;
  logic [9:0]        pix_idx;
  logic              pix_last;
  logic              frame_loaded;
  logic              frame_done;
  logic              busy;
  logic              err;

  modport master (
    input  start, row_valid, load_done, rd_start,
    output row_ack, load_en, rescale, bram_addr, pix_valid, pix_idx,
           pix_last, frame_loaded, frame_done, busy, err
  );

  modport slave (
    output start, row_valid, load_done, rd_start,
    input  row_ack, load_en, rescale, bram_addr, pix_valid, pix_idx,
           pix_last, frame_loaded, frame_done, busy, err
  );
endinterface

// File: rtl/img_load_ctrl.sv
// Input-image BRAM sequencer: rescale pulse, row-by-row handshaked load with
// a gap cycle between rows, then an address-ordered pixel stream whose valid,
// index and last flags are delayed to line up with the BRAM read latency.
module img_load_ctrl #(
  parameter int ROWS      = 28,
  parameter int COLS      = 28,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  img_load_ctrl_if.master bus
);

  localparam int NPIX = ROWS * COLS;
  localparam int RW   = $clog2(ROWS + 1);
  localparam int WW   = $clog2(TIMEOUT + 2);
  localparam int DW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(COLS);
  localparam logic [9:0]        LAST = 10'(NPIX - 1);

  if (BASE_ADDR + NPIX - 1 >= (1 << ADDR_W)) begin : g_addr_range_chk
    $error("img_load_ctrl: BASE_ADDR+ROWS*COLS-1 does not fit in ADDR_W bits");
  end
  if (NPIX > 1024) begin : g_pix_range_chk
    $error("img_load_ctrl: ROWS*COLS exceeds the 10-bit pixel index");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_lat_range_chk
    $error("img_load_ctrl: RD_LAT must be in 1..4");
  end

  typedef enum logic [3:0] {
    IDLE, RESCALE, WAIT_ROW, LOAD, GAP, LOADED, STREAM, DRAIN, ERR
  } state_t;

  state_t            state;
  logic [RW-1:0]     row_cnt;
  logic [9:0]        rd_cnt;
  logic [WW-1:0]     wait_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] row_base;
  logic [RD_LAT-1:0] vld_sr;
  logic [RD_LAT-1:0] last_sr;
  logic [9:0]        idx_sr [RD_LAT];

  // Main sequencer: state, counters and every registered control output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      row_cnt          <= '0;
      rd_cnt           <= '0;
      wait_cnt         <= '0;
      drain_cnt        <= '0;
      row_base         <= BASE;
      bus.row_ack      <= 1'b0;
      bus.load_en      <= 1'b0;
      bus.rescale      <= 1'b0;
      bus.bram_addr    <= BASE;
      bus.frame_loaded <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.busy         <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.row_ack    <= 1'b0;
      bus.rescale    <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE, LOADED, ERR: begin
          if (bus.start) begin
            state            <= RESCALE;
            row_cnt          <= '0;
            rd_cnt           <= '0;
            row_base         <= BASE;
            bus.err          <= 1'b0;
            bus.rescale      <= 1'b1;
            bus.busy         <= 1'b1;
            bus.frame_loaded <= 1'b0;
          end else if (state == LOADED && bus.rd_start) begin
            state            <= STREAM;
            rd_cnt           <= '0;
            bus.bram_addr    <= BASE;
            bus.busy         <= 1'b1;
            bus.frame_loaded <= 1'b0;
          end
        end
        RESCALE: begin
          state <= WAIT_ROW;
        end
        WAIT_ROW: begin
          if (bus.row_valid) begin
            state         <= LOAD;
            wait_cnt      <= '0;
            bus.load_en   <= 1'b1;
            bus.bram_addr <= row_base;
          end
        end
        LOAD: begin
          if (bus.load_done) begin
            state         <= GAP;
            bus.load_en   <= 1'b0;
            bus.bram_addr <= BASE;
            bus.row_ack   <= 1'b1;
            row_cnt       <= row_cnt + RW'(1);
            row_base      <= row_base + STEP;
          end else if (wait_cnt >= WW'(TIMEOUT)) begin
            state         <= ERR;
            bus.load_en   <= 1'b0;
            bus.bram_addr <= BASE;
            bus.err       <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        GAP: begin
          if (row_cnt == RW'(ROWS)) begin
            state            <= LOADED;
            bus.frame_loaded <= 1'b1;
            bus.busy         <= 1'b0;
          end else begin
            state <= WAIT_ROW;
          end
        end
        STREAM: begin
          if (rd_cnt == LAST) begin
            state         <= DRAIN;
            drain_cnt     <= '0;
            bus.bram_addr <= BASE;
          end else begin
            rd_cnt        <= rd_cnt + 10'd1;
            bus.bram_addr <= BASE + ADDR_W'(rd_cnt + 10'd1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DW'(RD_LAT - 1)) begin
            state          <= IDLE;
            bus.frame_done <= 1'b1;
            bus.busy       <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay the issue flag, index and last marker by the BRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_sr[i] <= '0;
    end else begin
      vld_sr[0]  <= (state == STREAM);
      last_sr[0] <= (state == STREAM) && (rd_cnt == LAST);
      idx_sr[0]  <= (state == STREAM) ? rd_cnt : 10'd0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
        idx_sr[i]  <= idx_sr[i-1];
      end
    end
  end

  assign bus.pix_valid = vld_sr[RD_LAT-1];
  assign bus.pix_last  = last_sr[RD_LAT-1];
  assign bus.pix_idx   = idx_sr[RD_LAT-1];

endmodule

// File: tb/tb_img_load_ctrl.sv
// Directed bench for img_load_ctrl: a BRAM/upstream model around a BASE_ADDR=0
// instance (TIMEOUT=15) plus a BASE_ADDR=10 instance for base-address sweeps.
module tb_img_load_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  img_load_ctrl_if #(.ADDR_W(11)) bus0 ();
  img_load_ctrl_if #(.ADDR_W(11)) bus1 ();

  img_load_ctrl #(
    .ROWS(28), .COLS(28), .ADDR_W(11), .BASE_ADDR(0), .RD_LAT(1), .TIMEOUT(15)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master)
  );

  img_load_ctrl #(
    .ROWS(28), .COLS(28), .ADDR_W(11), .BASE_ADDR(10), .RD_LAT(1), .TIMEOUT(255)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse the command inputs for exactly one cycle, starting at a falling edge.
  task automatic applyStimulus(input bit start0, input bit rd0, input bit start1);
    bus0.start    = start0;
    bus0.rd_start = rd0;
    bus1.start    = start1;
    @(negedge clk);
    bus0.start    = 1'b0;
    bus0.rd_start = 1'b0;
    bus1.start    = 1'b0;
  endtask

  logic [15:0] mem [2048];
  logic [15:0] dout;
  int          ld_cnt = 0;
  bit          hang   = 1'b0;
  int          up_row = 0;

  // BRAM model: one-cycle read latency; a row lands two cycles into each load.
  always @(posedge clk) begin
    dout <= mem[bus0.bram_addr];
    if (!bus0.load_en) begin
      ld_cnt         <= 0;
      bus0.load_done <= 1'b0;
    end else begin
      ld_cnt <= ld_cnt + 1;
      if (ld_cnt == 1 && !hang) begin
        bus0.load_done <= 1'b1;
        for (int c = 0; c < 28; c++)
          mem[11'(int'(bus0.bram_addr) + c)] <= 16'(up_row * 28 + c + 1);
      end else begin
        bus0.load_done <= 1'b0;
      end
    end
  end

  // Second instance's BRAM acknowledges each load one cycle after it starts.
  always @(posedge clk) begin
    bus1.load_done <= bus1.load_en && !bus1.load_done;
  end

  int stall_cnt   = 0;
  bit stall_en    = 1'b0;
  bit stall_done  = 1'b0;
  bit prev_le     = 1'b0;
  bit last_seen   = 1'b0;
  bit done_seen   = 1'b0;
  int exp_idx     = 0;
  int rescale_cnt = 0;
  int ack_cnt     = 0;

  // Upstream row source and pixel-stream scoreboard for the first instance.
  always @(negedge clk) begin
    if (bus0.rescale) begin
      up_row    = 0;
      exp_idx   = 0;
      done_seen = 1'b0;
      ack_cnt   = 0;
      rescale_cnt++;
    end
    if (bus0.load_en && !prev_le)
      checkOutput("row_base", 32'(bus0.bram_addr), 32'(up_row * 28));
    prev_le = bus0.load_en;
    if (bus0.row_ack) begin
      ack_cnt++;
      up_row++;
      if (up_row == 3 && stall_en && !stall_done) begin
        stall_cnt  = 5;
        stall_done = 1'b1;
      end
    end else if (stall_cnt > 0) begin
      checkOutput("stall_load_en", 32'(bus0.load_en), 0);
      checkOutput("stall_addr", 32'(bus0.bram_addr), 0);
      stall_cnt--;
    end
    bus0.row_valid = (up_row < 28) && (stall_cnt == 0);

    if (last_seen) begin
      checkOutput("frame_done", 32'(bus0.frame_done), 1);
      if (bus0.frame_done) done_seen = 1'b1;
      last_seen = 1'b0;
    end
    if (bus0.pix_valid) begin
      checkOutput("pix_idx", 32'(bus0.pix_idx), 32'(exp_idx));
      checkOutput("pix_data", 32'(dout), 32'(exp_idx + 1));
      checkOutput("pix_last", 32'(bus0.pix_last), 32'(exp_idx == 783));
      if (exp_idx == 783) last_seen = 1'b1;
      exp_idx++;
    end else if (exp_idx > 0 && exp_idx < 784) begin
      checkOutput("stream_gap", 32'(bus0.pix_valid), 1);
    end
  end

  int up1        = 0;
  int last_base1 = -1;
  bit prev_le1   = 1'b0;

  // Base-address tracker for the BASE_ADDR=10 instance.
  always @(negedge clk) begin
    if (bus1.rescale) up1 = 0;
    if (bus1.load_en && !prev_le1) begin
      checkOutput("base10_row", 32'(bus1.bram_addr), 32'(10 + up1 * 28));
      last_base1 = int'(bus1.bram_addr);
    end
    prev_le1 = bus1.load_en;
    if (bus1.row_ack) up1++;
  end

  initial begin
    int r0;
    int lcnt;
    rst           = 1'b1;
    bus0.start    = 1'b0;
    bus0.rd_start = 1'b0;
    bus1.start    = 1'b0;
    bus1.rd_start = 1'b0;
    bus1.row_valid = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_load_en", 32'(bus0.load_en), 0);
    checkOutput("rst_busy", 32'(bus0.busy), 0);
    checkOutput("rst_addr", 32'(bus0.bram_addr), 0);
    checkOutput("rst_err", 32'(bus0.err), 0);
    checkOutput("rst_rescale", 32'(bus0.rescale), 0);
    checkOutput("rst_loaded", 32'(bus0.frame_loaded), 0);
    checkOutput("rst_pix_valid", 32'(bus0.pix_valid), 0);
    checkOutput("rst_addr_base10", 32'(bus1.bram_addr), 10);
    rst = 1'b0;
    @(negedge clk);

    // Start latency, then a reset in the middle of a stuck load.
    hang = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rescale_pulse", 32'(bus0.rescale), 1);
    checkOutput("busy_after_start", 32'(bus0.busy), 1);
    checkOutput("no_early_load", 32'(bus0.load_en), 0);
    @(negedge clk);
    checkOutput("rescale_once", 32'(bus0.rescale), 0);
    @(negedge clk);
    checkOutput("first_load_en", 32'(bus0.load_en), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_drop_load_en", 32'(bus0.load_en), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_load_en", 32'(bus0.load_en), 0);
    checkOutput("midrst_busy", 32'(bus0.busy), 0);
    checkOutput("midrst_addr", 32'(bus0.bram_addr), 0);
    checkOutput("midrst_err", 32'(bus0.err), 0);

    // Full frame with a row stall; rd_start while busy must be ignored.
    hang     = 1'b0;
    stall_en = 1'b1;
    r0       = rescale_cnt;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rd_ignored_busy", 32'(bus0.busy), 1);
    for (int i = 0; i < 2000 && !bus0.frame_loaded; i++) @(negedge clk);
    checkOutput("frame_loaded", 32'(bus0.frame_loaded), 1);
    checkOutput("loaded_busy", 32'(bus0.busy), 0);
    checkOutput("loaded_addr", 32'(bus0.bram_addr), 0);
    checkOutput("rescale_count", 32'(rescale_cnt - r0), 1);
    checkOutput("row_ack_count", 32'(ack_cnt), 28);
    for (int i = 0; i < 2000 && !bus1.frame_loaded; i++) @(negedge clk);
    checkOutput("base10_loaded", 32'(bus1.frame_loaded), 1);
    checkOutput("base10_rows", 32'(up1), 28);
    checkOutput("base10_last", 32'(last_base1), 766);
    checkOutput("base10_idle_addr", 32'(bus1.bram_addr), 10);
    stall_en = 1'b0;

    // Readout with an ignored start in the middle of the stream.
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stream_busy", 32'(bus0.busy), 1);
    checkOutput("stream_not_loaded", 32'(bus0.frame_loaded), 0);
    checkOutput("first_addr", 32'(bus0.bram_addr), 0);
    checkOutput("pre_valid", 32'(bus0.pix_valid), 0);
    @(negedge clk);
    checkOutput("first_valid", 32'(bus0.pix_valid), 1);
    checkOutput("first_idx", 32'(bus0.pix_idx), 0);
    repeat (100) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_ignored_busy", 32'(bus0.busy), 1);
    checkOutput("start_ignored_rescale", 32'(bus0.rescale), 0);
    for (int i = 0; i < 2000 && !done_seen; i++) @(negedge clk);
    checkOutput("frame_done_seen", 32'(done_seen), 1);
    checkOutput("pix_count", 32'(exp_idx), 784);
    checkOutput("done_busy", 32'(bus0.busy), 0);

    // Load timeout, sticky error, then recovery through start.
    hang = 1'b1;
    lcnt = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100 && !bus0.err; i++) begin
      @(negedge clk);
      if (bus0.load_en) lcnt++;
    end
    checkOutput("timeout_cycles", 32'(lcnt), 16);
    checkOutput("timeout_err", 32'(bus0.err), 1);
    checkOutput("timeout_load_en", 32'(bus0.load_en), 0);
    checkOutput("timeout_busy", 32'(bus0.busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", 32'(bus0.err), 1);
    hang = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("err_cleared", 32'(bus0.err), 0);
    checkOutput("reload_rescale", 32'(bus0.rescale), 1);
    for (int i = 0; i < 2000 && !bus0.frame_loaded; i++) @(negedge clk);
    checkOutput("reload_loaded", 32'(bus0.frame_loaded), 1);
    checkOutput("reload_acks", 32'(ack_cnt), 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
